// File: rtl/i2s_stream_tx.sv
// ---------------------------------------------------------------------------
// i2s_stream_tx
//   Stereo serial-audio transmitter. Sample pairs arrive over a valid/ready
//   stream into a small FIFO. One pair is popped per frame, attenuated by an
//   arithmetic right shift, and serialised MSB-first in I2S (one-bit delay)
//   or left-justified format. MCLK, LRCK and SCK all come from one
//   free-running frame counter.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          serialiser run enable; low holds the counter and data at zero
//   in_valid    sample pair valid
//   in_ready    FIFO not full (combinational)
//   in_left     left sample, two's complement
//   in_right    right sample, two's complement
//   vol         attenuation shift 0..7, sampled when a frame loads
//   audio_mclk  master clock, counter bit MCLK_DIV_LOG2
//   audio_lrck  word select, 0 = left, 1 = right
//   audio_sck   bit clock, rising edge mid-bit
//   audio_sdin  registered serial data
//   fifo_level  FIFO occupancy
//   underrun    high in the cycle a frame loads from an empty FIFO
// ---------------------------------------------------------------------------
module i2s_stream_tx #(
  parameter int SAMPLE_W      = 16,
  parameter int SLOT_W        = 16,
  parameter int BIT_DIV_LOG2  = 4,
  parameter int MCLK_DIV_LOG2 = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int I2S_MODE      = 1,
  parameter int UNDERRUN_HOLD = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SAMPLE_W-1:0]         in_left,
  input  logic [SAMPLE_W-1:0]         in_right,
  input  logic [2:0]                  vol,
  output logic                        audio_mclk,
  output logic                        audio_lrck,
  output logic                        audio_sck,
  output logic                        audio_sdin,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
);

  localparam int CW      = BIT_DIV_LOG2 + $clog2(SLOT_W) + 1;
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int PAD_W   = SLOT_W - SAMPLE_W;

  logic [CW-1:0]         cnt_reg;
  logic                  en_d_reg;
  logic [FRAME_W-1:0]    sr_reg, sr_next;
  logic                  delay_reg, delay_next;
  logic                  sdin_reg, sdin_next;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg, level_next;
  logic [2*SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [2*SAMPLE_W-1:0] head_pair;
  logic [SLOT_W-1:0]     slot_data [2];

  logic full, empty, push, pop, load, bit_end, frame_end;

  assign full      = (level_reg == LVL_W'(FIFO_DEPTH));
  assign empty     = (level_reg == '0);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign frame_end = &cnt_reg;
  assign bit_end   = &cnt_reg[BIT_DIV_LOG2-1:0];
  // A frame loads at the last counter value, or in the first enabled cycle
  // (the counter is parked at zero while disabled).
  assign load      = en & (~en_d_reg | frame_end);
  assign pop       = load & ~empty;
  // Gated by rst_n so the pulse stays low while reset holds en_d_reg at 0.
  assign underrun  = load & empty & rst_n;
  assign head_pair = fifo_mem[rd_ptr_reg];

  // Sample-pair storage; entries need no reset since occupancy is tracked.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {in_left, in_right};
    end
  end

  // Per-channel datapath: channel 0 = left (upper half), 1 = right.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [SAMPLE_W-1:0] head_s;
      logic signed [SAMPLE_W-1:0] att_s;
      logic [SAMPLE_W-1:0]        last_reg;
      logic [SAMPLE_W-1:0]        ld_val;

      assign head_s = head_pair[(2-gi)*SAMPLE_W-1 -: SAMPLE_W];
      assign att_s  = head_s >>> vol;

      // The held pair is already attenuated; it is replayed as stored.
      always_comb begin
        ld_val = '0;
        if (pop) begin
          ld_val = att_s;
        end else if (UNDERRUN_HOLD != 0) begin
          ld_val = last_reg;
        end
      end

      // MSB-justify the sample in its slot; low bits are zero padding.
      assign slot_data[gi] = SLOT_W'(ld_val) << PAD_W;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          last_reg <= '0;
        end else if (pop) begin
          last_reg <= att_s;
        end
      end
    end
  endgenerate

  always_comb begin
    sr_next    = sr_reg;
    delay_next = delay_reg;
    if (!en) begin
      sr_next    = '0;
      delay_next = 1'b0;
    end else begin
      // The delay bit captures the outgoing left-justified bit at each bit
      // boundary, giving the one-bit-period lag of I2S.
      if (bit_end) begin
        delay_next = sr_reg[FRAME_W-1];
      end
      if (load) begin
        sr_next = {slot_data[0], slot_data[1]};
      end else if (bit_end) begin
        sr_next = {sr_reg[FRAME_W-2:0], 1'b0};
      end
    end
    sdin_next = (I2S_MODE != 0) ? delay_next : sr_next[FRAME_W-1];
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      en_d_reg   <= 1'b0;
      sr_reg     <= '0;
      delay_reg  <= 1'b0;
      sdin_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      cnt_reg    <= en ? cnt_reg + CW'(1) : '0;
      en_d_reg   <= en;
      sr_reg     <= sr_next;
      delay_reg  <= delay_next;
      sdin_reg   <= sdin_next;
      level_reg  <= level_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  assign audio_lrck = cnt_reg[CW-1];
  assign audio_sck  = cnt_reg[BIT_DIV_LOG2-1];
  assign audio_mclk = cnt_reg[MCLK_DIV_LOG2];
  assign audio_sdin = sdin_reg;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_i2s_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_stream_tx
//   Two transmitters share all inputs: dut_a is I2S with underrun hold,
//   dut_b is left-justified with zero-on-underrun. Stimulus pushes the
//   expected wire word of every frame into per-instance queues; a monitor
//   reassembles 32 bits per frame on SCK rising edges and pops/compares.
// ---------------------------------------------------------------------------
module tb_i2s_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic [2:0]  vol = '0;

  logic [1:0]  in_ready_w, mclk_w, lrck_w, sck_w, sdin_w, ur_w;
  logic [2:0]  level_a, level_b;

  always #5 clk = ~clk;

  i2s_stream_tx #(.I2S_MODE(1), .UNDERRUN_HOLD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .in_ready(in_ready_w[0]), .in_left(in_left), .in_right(in_right),
    .vol(vol), .audio_mclk(mclk_w[0]), .audio_lrck(lrck_w[0]),
    .audio_sck(sck_w[0]), .audio_sdin(sdin_w[0]), .fifo_level(level_a),
    .underrun(ur_w[0])
  );

  i2s_stream_tx #(.I2S_MODE(0), .UNDERRUN_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .in_ready(in_ready_w[1]), .in_left(in_left), .in_right(in_right),
    .vol(vol), .audio_mclk(mclk_w[1]), .audio_lrck(lrck_w[1]),
    .audio_sck(sck_w[1]), .audio_sdin(sdin_w[1]), .fifo_level(level_b),
    .underrun(ur_w[1])
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic        prev_a = 1'b0;
  int          ur_cnt [2] = '{0, 0};

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endfunction

  // wa/wb: attenuated {L,R} word each instance loads. The I2S wire word is
  // the previous word's last bit followed by this word minus its LSB.
  task automatic expect_frame(input logic [31:0] wa, input logic [31:0] wb,
                              input logic first);
    if (first) prev_a = 1'b0;
    exp_q0.push_back({prev_a, wa[31:1]});
    prev_a = wa[0];
    exp_q1.push_back(wb);
  endtask

  // Frame monitor: samples 1 time unit after the rising clock edge.
  int          bits [2] = '{0, 0};
  logic [31:0] dsh [2];
  logic [31:0] lsh [2];
  logic [1:0]  sck_prev = 2'b00;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || !en) begin
        bits[k] = 0;
      end else if (sck_w[k] && !sck_prev[k]) begin
        dsh[k] = {dsh[k][30:0], sdin_w[k]};
        lsh[k] = {lsh[k][30:0], lrck_w[k]};
        bits[k]++;
        if (bits[k] == 32) begin
          bits[k] = 0;
          check(k == 0 ? "lrck_pattern_a" : "lrck_pattern_b", lsh[k], 32'h0000FFFF);
          if (k == 0) begin
            if (exp_q0.size() == 0) begin
              n_cmp++; n_mis++;
              $display("FAIL frame_a: got %h expected no frame", dsh[k]);
            end else begin
              check("frame_a", dsh[k], exp_q0.pop_front());
            end
          end else begin
            if (exp_q1.size() == 0) begin
              n_cmp++; n_mis++;
              $display("FAIL frame_b: got %h expected no frame", dsh[k]);
            end else begin
              check("frame_b", dsh[k], exp_q1.pop_front());
            end
          end
        end
      end
      sck_prev[k] = sck_w[k];
    end
  end

  // Underrun pulses are counted mid-cycle so the short enable-rise load
  // window (en driven on the falling edge) is also seen.
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (ur_w[k]) ur_cnt[k]++;
    end
  end

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r,
                           output int waited);
    waited = 0;
    @(negedge clk);
    in_left = l; in_right = r; in_valid = 1'b1;
    while (!in_ready_w[0] && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_w[0]) begin
      n_cmp++; n_mis++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 5000 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Enable for n frames minus one cycle: all n frames are fully shifted out
  // and no extra frame load happens at the final wrap.
  task automatic run_frames(input int n, input int vol_at, input logic [2:0] vol_new);
    @(negedge clk);
    en = 1'b1;
    for (int c = 0; c < n * 512 - 1; c++) begin
      @(negedge clk);
      if (c + 1 == vol_at) vol = vol_new;
    end
    en = 1'b0;
  endtask

  int w;
  int ur0_a, ur0_b;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sdin", 32'(sdin_w), 32'h0);
    check("rst_mclk", 32'(mclk_w), 32'h0);
    check("rst_lrck", 32'(lrck_w), 32'h0);
    check("rst_sck", 32'(sck_w), 32'h0);
    check("rst_underrun", 32'(ur_w), 32'h0);
    check("rst_in_ready", 32'(in_ready_w), 32'h3);
    check("rst_level_a", 32'(level_a), 32'h0);
    check("rst_level_b", 32'(level_b), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame, vol=0
    push_pair(16'hA5C3, 16'h0F01, w);
    check("level_one_a", 32'(level_a), 32'h1);
    check("level_one_b", 32'(level_b), 32'h1);
    expect_frame(32'hA5C30F01, 32'hA5C30F01, 1'b1);
    ur0_a = ur_cnt[0]; ur0_b = ur_cnt[1];
    run_frames(1, -1, 3'd0);
    check("ur_basic_a", 32'(ur_cnt[0] - ur0_a), 32'd0);
    check("ur_basic_b", 32'(ur_cnt[1] - ur0_b), 32'd0);

    // Attenuation: vol=2 for first load, vol=7 for second
    vol = 3'd2;
    push_pair(16'h8000, 16'h0040, w);
    push_pair(16'h8000, 16'h0040, w);
    expect_frame(32'hE0000010, 32'hE0000010, 1'b1);
    expect_frame(32'hFF000000, 32'hFF000000, 1'b0);
    run_frames(2, 256, 3'd7);
    vol = 3'd0;

    // Underrun: one pair, three frames; vol change must not touch the hold
    push_pair(16'h1234, 16'hABCD, w);
    expect_frame(32'h1234ABCD, 32'h1234ABCD, 1'b1);
    expect_frame(32'h1234ABCD, 32'h00000000, 1'b0);
    expect_frame(32'h1234ABCD, 32'h00000000, 1'b0);
    ur0_a = ur_cnt[0]; ur0_b = ur_cnt[1];
    run_frames(3, 256, 3'd3);
    vol = 3'd0;
    check("ur_hold_a", 32'(ur_cnt[0] - ur0_a), 32'd2);
    check("ur_hold_b", 32'(ur_cnt[1] - ur0_b), 32'd2);

    // FIFO full: four pairs with en=0, fifth waits for the first pop
    push_pair(16'h0001, 16'h8001, w);
    push_pair(16'h0102, 16'h0304, w);
    push_pair(16'h1111, 16'h2222, w);
    push_pair(16'h7FFF, 16'h8000, w);
    check("full_level_a", 32'(level_a), 32'h4);
    check("full_in_ready", 32'(in_ready_w), 32'h0);
    @(negedge clk);
    in_left = 16'hC3C3; in_right = 16'h3C3C; in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("full_hold_level_b", 32'(level_b), 32'h4);
    expect_frame(32'h00018001, 32'h00018001, 1'b1);
    expect_frame(32'h01020304, 32'h01020304, 1'b0);
    expect_frame(32'h11112222, 32'h11112222, 1'b0);
    expect_frame(32'h7FFF8000, 32'h7FFF8000, 1'b0);
    expect_frame(32'hC3C33C3C, 32'hC3C33C3C, 1'b0);
    ur0_a = ur_cnt[0];
    fork
      run_frames(5, -1, 3'd0);
      begin
        push_pair(16'hC3C3, 16'h3C3C, w);
        check("fifth_accept_wait", 32'(w), 32'd1);
      end
    join
    check("ur_full_a", 32'(ur_cnt[0] - ur0_a), 32'd0);
    check("drained_level_a", 32'(level_a), 32'h0);

    // Reset mid-frame at cnt=266 (lrck, sck and mclk all high)
    push_pair(16'h00FF, 16'h8000, w);
    push_pair(16'h1111, 16'h1111, w);
    @(negedge clk);
    en = 1'b1;
    repeat (266) @(negedge clk);
    check("pre_rst_sdin", 32'(sdin_w), 32'h3);
    check("pre_rst_clocks", {8'(mclk_w), 8'(lrck_w), 8'(sck_w)}, 32'h00030303);
    check("pre_rst_level_a", 32'(level_a), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sdin", 32'(sdin_w), 32'h0);
    check("mid_rst_clocks", {8'(mclk_w), 8'(lrck_w), 8'(sck_w)}, 32'h0);
    check("mid_rst_level_a", 32'(level_a), 32'h0);
    check("mid_rst_level_b", 32'(level_b), 32'h0);
    repeat (3) @(negedge clk);
    expect_frame(32'h00000000, 32'h00000000, 1'b1);
    ur0_a = ur_cnt[0]; ur0_b = ur_cnt[1];
    rst_n = 1'b1;
    repeat (511) @(negedge clk);
    en = 1'b0;
    check("ur_post_rst_a", 32'(ur_cnt[0] - ur0_a), 32'd1);
    check("ur_post_rst_b", 32'(ur_cnt[1] - ur0_b), 32'd1);

    repeat (5) @(negedge clk);
    check("leftover_exp_a", 32'(exp_q0.size()), 32'd0);
    check("leftover_exp_b", 32'(exp_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
